// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - 4-digit common-anode seven-segment scan driver
module seven_seg_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] thousands,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic [3:0] dp_en,
    input  logic       blank_lz,
    input  logic       enable,
    input  logic [3:0] duty,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit_sel,
    output logic       frame_done
);

    localparam int PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SLOT = REFRESH_DIV / 16;

    logic [PW-1:0] pre;
    logic [1:0]    idx;
    logic [3:0]    sh [4];

    logic          tick;
    logic [3:0]    cur;
    logic          blank;
    logic          lit;
    logic [31:0]   thr;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign tick = (pre == PW'(REFRESH_DIV - 1));

    // Blanking looks at the frozen shadow so a digit never flickers mid-frame.
    always_comb begin
        cur   = sh[idx];
        blank = 1'b0;
        case (idx)
            2'd3: blank = (sh[3] == 4'd0);
            2'd2: blank = (sh[3] == 4'd0) && (sh[2] == 4'd0);
            2'd1: blank = (sh[3] == 4'd0) && (sh[2] == 4'd0) && (sh[1] == 4'd0);
            default: blank = 1'b0;
        endcase
        blank = blank && blank_lz;
        thr   = (32'(duty) + 32'd1) * 32'(SLOT);
        lit   = enable && !blank && (32'(pre) < thr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre        <= '0;
            idx        <= 2'd0;
            for (int i = 0; i < 4; i++) sh[i] <= 4'd0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            digit_sel  <= 2'd0;
            frame_done <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) idx <= idx + 2'd1;
            if (tick && idx == 2'd3) begin
                sh[0] <= ones;
                sh[1] <= tens;
                sh[2] <= hundreds;
                sh[3] <= thousands;
            end
            frame_done <= tick && (idx == 2'd3);
            digit_sel  <= idx;
            an         <= lit ? ~(4'b0001 << idx) : 4'b1111;
            seg        <= lit ? decode(cur) : 7'b1111111;
            dp         <= lit ? ~dp_en[idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - bench for seven_seg_scan against a timeline model
module tb_seven_seg_scan;

    localparam int RD = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] thousands, hundreds, tens, ones;
    logic [3:0] dp_en;
    logic       blank_lz;
    logic       enable;
    logic [3:0] duty;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_sel;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;

    // Model: cycles since reset release, and the digits latched at the last frame boundary.
    int         m_t = 0;
    logic [3:0] m_sh [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                             7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    seven_seg_scan #(.REFRESH_DIV(RD)) dut (
        .clk(clk), .reset(reset),
        .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
        .dp_en(dp_en), .blank_lz(blank_lz), .enable(enable), .duty(duty),
        .an(an), .seg(seg), .dp(dp), .digit_sel(digit_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, m_t, obs, exp);
        end
    endtask

    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [1:0] e_sel;
        logic       e_fd;
        logic [3:0] in_d [4];
        int pos, slot, thr;
        bit blank;
        pos  = m_t % RD;
        slot = (m_t / RD) % 4;
        in_d = '{ones, tens, hundreds, thousands};
        if (reset) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_sel = 2'd0; e_fd = 1'b0;
        end else begin
            blank = 1'b0;
            if (blank_lz && slot > 0) begin
                blank = 1'b1;
                for (int j = slot; j < 4; j++) if (m_sh[j] != 4'd0) blank = 1'b0;
            end
            thr   = (int'(duty) + 1) * (RD / 16);
            e_sel = 2'(slot);
            e_fd  = (pos == RD - 1) && (slot == 3);
            if (enable && !blank && pos < thr) begin
                e_an  = ~(4'b0001 << slot);
                e_seg = pat[m_sh[slot]];
                e_dp  = ~dp_en[slot];
            end else begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("an", 8'(an), 8'(e_an));
        chk("seg", 8'(seg), 8'(e_seg));
        chk("dp", 8'(dp), 8'(e_dp));
        chk("digit_sel", 8'(digit_sel), 8'(e_sel));
        chk("frame_done", 8'(frame_done), 8'(e_fd));
        if (reset) begin
            m_t  = 0;
            m_sh = '{4'd0, 4'd0, 4'd0, 4'd0};
        end else begin
            if (pos == RD - 1 && slot == 3) m_sh = in_d;
            m_t++;
        end
    endtask

    task automatic set_digits(input int d3, input int d2, input int d1, input int d0);
        thousands = 4'(d3); hundreds = 4'(d2); tens = 4'(d1); ones = 4'(d0);
    endtask

    initial begin
        reset = 1'b1; set_digits(1, 2, 3, 4);
        dp_en = 4'b0000; blank_lz = 1'b0; enable = 1'b1; duty = 4'd15;
        repeat (2) step();
        reset = 1'b0;
        repeat (128) step();
        // Change mid-frame: must not show until the next frame.
        repeat (10) step();
        set_digits(5, 6, 7, 8);
        repeat (118) step();
        blank_lz = 1'b1; set_digits(0, 0, 4, 2);
        repeat (128) step();
        set_digits(0, 0, 0, 0);
        repeat (128) step();
        blank_lz = 1'b0; set_digits(1, 2, 3, 4);
        duty = 4'd3;  repeat (64) step();
        duty = 4'd0;  repeat (64) step();
        duty = 4'd15; dp_en = 4'b0100; ones = 4'd11;
        repeat (128) step();
        enable = 1'b0; repeat (64) step();
        enable = 1'b1; repeat (32) step();
        reset = 1'b1; step();
        reset = 1'b0; repeat (128) step();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0)
                set_digits($urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) duty = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) dp_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            enable = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 249) == 0);
            step();
        end
        reset = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Sequential digit-multiplexing driver for a 4-digit common-anode seven-segment display.
- Sits directly downstream of the combinational 16-bit binary-to-BCD converter and consumes its thousands/hundreds/tens/ones digits.
- Time-multiplexes one digit at a time onto shared cathodes.
- Adds tear-free frame snapshotting, leading-zero blanking, per-digit decimal points and PWM brightness.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz gives 1 kHz per digit, 250 Hz per frame); must be a multiple of 16 and >= 16.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
thousands  input  4  BCD digit 3 (leftmost)
hundreds  input  4  BCD digit 2
tens  input  4  BCD digit 1
ones  input  4  BCD digit 0 (rightmost)
dp_en  input  4  decimal-point enable per digit, bit i = digit i
blank_lz  input  1  1 = blank leading zeros
enable  input  1  0 = all digits dark
duty  input  4  brightness; on-time = (duty+1)/16 of each slot
an  output  4  anodes, active-low, an[i] = digit i
seg  output  7  cathodes, active-low, seg[6:0] = {g,f,e,d,c,b,a}
dp  output  1  decimal-point cathode, active-low
digit_sel  output  2  index of the digit currently driven
frame_done  output  1  one-cycle pulse at the end of each 4-digit frame

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - pre = 0, idx = 0, shadow digits = 0.
  - an = 4'b1111, seg = 7'b1111111, dp = 1, digit_sel = 0, frame_done = 0.
- Prescaler pre:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (pre == REFRESH_DIV-1).
- Digit index idx:
  - Advances 0→1→2→3→0 on tick.
  - digit_sel = idx (registered).
- Snapshot and frame_done:
  - On a tick with idx==3, the four input digits are captured into shadow registers.
  - frame_done is 1 for exactly that cycle.
  - Inputs that change mid-frame never appear until the next frame.
  - The first frame after reset displays the zeroed shadow.
- Decode (from the shadow digit at idx):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Values 10-15 show dash = 0111111 (error flag).
- Leading-zero blanking (when blank_lz=1, evaluated on the shadow):
  - Digit 3 blank if it is 0.
  - Digit 2 blank if digits 3 and 2 are 0.
  - Digit 1 blank if digits 3..1 are 0.
  - Digit 0 is never blanked.
  - Values 10-15 count as non-zero.
- Brightness:
  - threshold = (duty+1)*(REFRESH_DIV/16).
  - The slot is lit while pre < threshold; duty=15 gives full on.
  - duty is sampled every cycle, so a change takes effect within the current slot.
- Output rules:
  - an[idx] = 0 only when enable=1, the digit is not blanked, and pre < threshold; all other an bits are 1.
  - When the digit is dark, seg = 1111111 and dp = 1.
  - Otherwise seg = decoded pattern and dp = ~dp_en[idx].
- Latency: all outputs are registered and lag pre/idx by exactly one cycle.
- enable=0: pre, idx, snapshot and frame_done keep running; only an/seg/dp are forced dark.
- Reset mid-frame: returns to the reset state at the next edge; shadow contents are lost.

Test Plan:
1. REFRESH_DIV=16, reset 2 cycles, enable=1, duty=15, blank_lz=0, inputs 1/2/3/4 → first 64 cycles show "0000" (an cycles 1110, 1101, 1011, 0111, 16 cycles each, seg=1000000); frame_done pulses on cycle 63; next frame shows an=1110/seg=0011001 (4), 1101/0110000 (3), 1011/0100100 (2), 0111/1111001 (1).
2. Inputs changed from 1234 to 5678 at cycle 10 of a frame → that frame still shows 1,2,3,4; the next frame shows 8 (0000000), 7, 6 (0000010), 5 (0010010).
3. blank_lz=1, inputs 0/0/4/2 → an[3] and an[2] stay 1 for the whole frame; digit 1 shows 4 and digit 0 shows 2. Inputs 0/0/0/0 → only digit 0 lights, showing 1000000.
4. duty=3 with REFRESH_DIV=16 → in every slot the active anode is low for exactly 4 cycles then high for 12; duty=0 → 1 cycle low per slot.
5. dp_en=4'b0100, ones=11 → dp=0 only while digit_sel=2; digit 0 shows dash 0111111.
6. enable=0 for one full frame → an=1111, seg=1111111, dp=1 throughout while frame_done still pulses every 64 cycles; assert reset at slot 2 → next cycle an=1111, digit_sel=0, and the following frame shows zeros.
